// File: rtl/cpu_defs.sv
// Shared CPU pipeline types: IF/ID/EX bundles, decoder output, bypass and memory requests.
package cpu_defs;

  localparam int unsigned N_REGS     = 32;
  localparam int unsigned REG_ADDR_W = $clog2(N_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // OP_SLL must stay at encoding 0 so an all-zero pipe_id reads as a nop.
  typedef enum logic [5:0] {
    OP_SLL, OP_SRL, OP_SRA, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_JR, OP_MULT, OP_DIV, OP_ADDIU, OP_SLTI, OP_SLTIU,
    OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_BEQ, OP_BNE, OP_J, OP_JAL,
    OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW, OP_MFC0, OP_MTC0, OP_INVALID
  } oper_t;

  typedef struct packed {
    logic valid;
  } except_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] vaddr;
    logic        iaddr_ex;
  } pipe_if_t;

  typedef struct packed {
    logic        we;
    reg_addr_t   waddr;
    logic [31:0] wrdata;
  } regs_wreq_t;

  typedef struct packed {
    oper_t     op;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;        // destination GPR, 0 when the op writes none
    logic [4:0] shamt;
    logic      is_load;
    logic      is_store;
    logic      is_branch;
    logic      is_multicyc;
    logic      use_imm;
    logic      imm_sext;
    logic      imm_upper;
    logic [4:0] cp0_addr;
    logic [2:0] cp0_sel;
  } decode_resp_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] vaddr;
    logic [31:0] wrdata;
    logic [3:0]  byteenable;
  } dcache_req_t;

  typedef struct packed {
    logic [4:0] raddr;
    logic [2:0] rsel;
  } cp0_rreq_t;

  typedef struct packed {
    logic         valid;
    oper_t        op;
    logic [31:0]  inst;
    logic [31:0]  vaddr;
    logic         iaddr_ex;
    logic         delayslot;
    logic [31:0]  regs_rddata0;
    logic [31:0]  regs_rddata1;
    decode_resp_t decoded;
    dcache_req_t  dcache_req;
    cp0_rreq_t    cp0_rreq;
  } pipe_id_t;

  // Operand bypass: r0 is constant, the younger EX result beats the WB result.
  function automatic logic [31:0] sel_operand(reg_addr_t addr, logic [31:0] rf_data,
                                              regs_wreq_t ex, regs_wreq_t wb);
    if (addr == '0) return '0;
    if (ex.we && ex.waddr == addr) return ex.wrdata;
    if (wb.we && wb.waddr == addr) return wb.wrdata;
    return rf_data;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational MIPS32 subset decoder: instruction word to decode_resp_t.
module inst_decoder
  import cpu_defs::*;
(
  input  logic [31:0]  inst,
  output decode_resp_t resp
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];

  // Common fields are always extracted; the opcode case fills op class and destination.
  always_comb begin
    resp          = '0;
    resp.op       = OP_INVALID;
    resp.rs       = inst[25:21];
    resp.rt       = inst[20:16];
    resp.shamt    = inst[10:6];
    resp.cp0_addr = inst[15:11];
    resp.cp0_sel  = inst[2:0];
    case (opcode)
      6'h00: begin
        resp.rd = inst[15:11];
        case (funct)
          6'h00: resp.op = OP_SLL;
          6'h02: resp.op = OP_SRL;
          6'h03: resp.op = OP_SRA;
          6'h08: begin resp.op = OP_JR; resp.is_branch = 1'b1; resp.rd = '0; end
          6'h18: begin resp.op = OP_MULT; resp.is_multicyc = 1'b1; resp.rd = '0; end
          6'h1a: begin resp.op = OP_DIV; resp.is_multicyc = 1'b1; resp.rd = '0; end
          6'h21: resp.op = OP_ADDU;
          6'h23: resp.op = OP_SUBU;
          6'h24: resp.op = OP_AND;
          6'h25: resp.op = OP_OR;
          6'h26: resp.op = OP_XOR;
          6'h27: resp.op = OP_NOR;
          6'h2a: resp.op = OP_SLT;
          6'h2b: resp.op = OP_SLTU;
          default: resp.rd = '0;
        endcase
      end
      6'h02: begin resp.op = OP_J; resp.is_branch = 1'b1; end
      6'h03: begin resp.op = OP_JAL; resp.is_branch = 1'b1; resp.rd = 5'd31; end
      6'h04: begin resp.op = OP_BEQ; resp.is_branch = 1'b1; end
      6'h05: begin resp.op = OP_BNE; resp.is_branch = 1'b1; end
      6'h09: begin resp.op = OP_ADDIU; resp.use_imm = 1'b1; resp.imm_sext = 1'b1;
                   resp.rd = inst[20:16]; end
      6'h0a: begin resp.op = OP_SLTI; resp.use_imm = 1'b1; resp.imm_sext = 1'b1;
                   resp.rd = inst[20:16]; end
      6'h0b: begin resp.op = OP_SLTIU; resp.use_imm = 1'b1; resp.imm_sext = 1'b1;
                   resp.rd = inst[20:16]; end
      6'h0c: begin resp.op = OP_ANDI; resp.use_imm = 1'b1; resp.rd = inst[20:16]; end
      6'h0d: begin resp.op = OP_ORI; resp.use_imm = 1'b1; resp.rd = inst[20:16]; end
      6'h0e: begin resp.op = OP_XORI; resp.use_imm = 1'b1; resp.rd = inst[20:16]; end
      6'h0f: begin resp.op = OP_LUI; resp.use_imm = 1'b1; resp.imm_upper = 1'b1;
                   resp.rd = inst[20:16]; end
      6'h10: begin
        if (inst[25:21] == 5'h00) begin
          resp.op = OP_MFC0;
          resp.rd = inst[20:16];
        end else if (inst[25:21] == 5'h04) begin
          resp.op = OP_MTC0;
        end
      end
      6'h20: begin resp.op = OP_LB; resp.is_load = 1'b1; resp.rd = inst[20:16]; end
      6'h24: begin resp.op = OP_LBU; resp.is_load = 1'b1; resp.rd = inst[20:16]; end
      6'h23: begin resp.op = OP_LW; resp.is_load = 1'b1; resp.rd = inst[20:16]; end
      6'h28: begin resp.op = OP_SB; resp.is_store = 1'b1; end
      6'h2b: begin resp.op = OP_SW; resp.is_store = 1'b1; end
      default: resp.op = OP_INVALID;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// ID stage: decode, register read with EX/WB bypass, delay-slot tracking, MTC0->MFC0 bubble.
module inst_decode_stage
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ready_i,
  output logic        ready_o,
  input  except_req_t except_req,
  input  pipe_if_t    pipe_if,
  output reg_addr_t   regs_raddr0,
  output reg_addr_t   regs_raddr1,
  input  logic [31:0] regs_rddata0,
  input  logic [31:0] regs_rddata1,
  input  regs_wreq_t  ex_wreq,
  input  regs_wreq_t  wb_wreq,
  output pipe_id_t    pipe_id
);

  decode_resp_t dec;
  dcache_req_t  dcache_req;
  pipe_id_t     pipe_id_n;
  logic [31:0]  operand0;
  logic [31:0]  rt_val;
  logic [31:0]  operand1;
  logic [31:0]  mem_addr;
  logic         ds_pending;
  logic         cp0_stall;

  inst_decoder u_inst_decoder (
    .inst (pipe_if.inst),
    .resp (dec)
  );

  assign regs_raddr0 = dec.rs;
  assign regs_raddr1 = dec.rt;

  // MFC0 must not read CP0 in the cycle right after an MTC0 is handed to EX.
  assign cp0_stall = pipe_id.valid && (pipe_id.op == OP_MTC0) && (dec.op == OP_MFC0)
                     && pipe_if.valid;
  assign ready_o   = ready_i && !cp0_stall;

  // Bypassed operands; immediate forms replace operand1 while rt is still read.
  always_comb begin
    operand0 = sel_operand(dec.rs, regs_rddata0, ex_wreq, wb_wreq);
    rt_val   = sel_operand(dec.rt, regs_rddata1, ex_wreq, wb_wreq);
    operand1 = rt_val;
    if (dec.use_imm) begin
      if (dec.imm_upper) operand1 = {pipe_if.inst[15:0], 16'h0000};
      else if (dec.imm_sext) operand1 = {{16{pipe_if.inst[15]}}, pipe_if.inst[15:0]};
      else operand1 = {16'h0000, pipe_if.inst[15:0]};
    end
  end

  // Data cache request, with store data steered onto its byte lane.
  always_comb begin
    dcache_req = '0;
    mem_addr   = operand0 + {{16{pipe_if.inst[15]}}, pipe_if.inst[15:0]};
    if (pipe_if.valid) begin
      dcache_req.read   = dec.is_load;
      dcache_req.write  = dec.is_store;
      dcache_req.vaddr  = mem_addr;
      dcache_req.wrdata = operand1 << {mem_addr[1:0], 3'b000};
      case (dec.op)
        OP_LB, OP_LBU, OP_SB: dcache_req.byteenable = 4'b0001 << mem_addr[1:0];
        OP_LW, OP_SW:         dcache_req.byteenable = 4'b1111;
        default:              dcache_req.byteenable = 4'b0000;
      endcase
    end
  end

  // Next ID->EX bundle assembled from the current IF instruction.
  always_comb begin
    pipe_id_n                = '0;
    pipe_id_n.valid          = pipe_if.valid;
    pipe_id_n.op             = dec.op;
    pipe_id_n.inst           = pipe_if.inst;
    pipe_id_n.vaddr          = pipe_if.vaddr;
    pipe_id_n.iaddr_ex       = pipe_if.iaddr_ex;
    pipe_id_n.delayslot      = pipe_if.valid && ds_pending;
    pipe_id_n.regs_rddata0   = operand0;
    pipe_id_n.regs_rddata1   = operand1;
    pipe_id_n.decoded        = dec;
    pipe_id_n.dcache_req     = dcache_req;
    pipe_id_n.cp0_rreq.raddr = pipe_if.inst[15:11];
    pipe_id_n.cp0_rreq.rsel  = pipe_if.inst[2:0];
  end

  // Stage register: flush beats stall, stall holds, CP0 hazard loads a bubble.
  always_ff @(posedge clk) begin
    if (rst || except_req.valid) begin
      pipe_id    <= '0;
      ds_pending <= 1'b0;
    end else if (ready_i) begin
      if (cp0_stall) begin
        pipe_id <= '0;
      end else begin
        pipe_id <= pipe_id_n;
        if (pipe_if.valid) ds_pending <= dec.is_branch;
      end
    end
  end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage: bypass, immediates, memory, delay slot, CP0 bubble,
// backpressure and flush.
module tb_inst_decode_stage;
  import cpu_defs::*;

  logic        clk;
  logic        rst;
  logic        ready_i;
  logic        ready_o;
  except_req_t except_req;
  pipe_if_t    pipe_if;
  reg_addr_t   regs_raddr0;
  reg_addr_t   regs_raddr1;
  logic [31:0] regs_rddata0;
  logic [31:0] regs_rddata1;
  regs_wreq_t  ex_wreq;
  regs_wreq_t  wb_wreq;
  pipe_id_t    pipe_id;

  logic [31:0] rf [32];
  int          n_vec;
  int          n_err;

  inst_decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ready_i      (ready_i),
    .ready_o      (ready_o),
    .except_req   (except_req),
    .pipe_if      (pipe_if),
    .regs_raddr0  (regs_raddr0),
    .regs_raddr1  (regs_raddr1),
    .regs_rddata0 (regs_rddata0),
    .regs_rddata1 (regs_rddata1),
    .ex_wreq      (ex_wreq),
    .wb_wreq      (wb_wreq),
    .pipe_id      (pipe_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational register file model.
  always_comb begin
    regs_rddata0 = rf[regs_raddr0];
    regs_rddata1 = rf[regs_raddr1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic [31:0] inst, input logic [31:0] vaddr);
    pipe_if.valid    = 1'b1;
    pipe_if.inst     = inst;
    pipe_if.vaddr    = vaddr;
    pipe_if.iaddr_ex = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_i = 1'b1; except_req = '0; ex_wreq = '0; wb_wreq = '0;
    set_if(32'h00A01821, 32'hBFC00000);
    step(); step();
    n_vec++; if (pipe_id !== '0) begin n_err++;
      $display("FAIL reset_pipe_id: got %h want 0", pipe_id); end
    n_vec++; if (ready_o !== 1'b1) begin n_err++;
      $display("FAIL reset_ready_hi: got %b want 1", ready_o); end
    n_vec++; if (regs_raddr0 !== 5'd5 || regs_raddr1 !== 5'd0) begin n_err++;
      $display("FAIL reset_raddr: got %0d/%0d want 5/0", regs_raddr0, regs_raddr1); end
    ready_i = 1'b0; #1;
    n_vec++; if (ready_o !== 1'b0) begin n_err++;
      $display("FAIL reset_ready_lo: got %b want 0", ready_o); end
    ready_i = 1'b1; pipe_if.valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_forward();
    ex_wreq.we = 1'b1; ex_wreq.waddr = 5'd5; ex_wreq.wrdata = 32'hAAAA0000;
    wb_wreq.we = 1'b1; wb_wreq.waddr = 5'd5; wb_wreq.wrdata = 32'h00001111;
    set_if(32'h00A01821, 32'hBFC00000);   // addu r3,r5,r0
    step();
    n_vec++; if (pipe_id.valid !== 1'b1 || pipe_id.op !== OP_ADDU) begin n_err++;
      $display("FAIL fwd_op: got v=%b op=%0d want v=1 op=%0d", pipe_id.valid, pipe_id.op,
               OP_ADDU); end
    n_vec++; if (pipe_id.regs_rddata0 !== 32'hAAAA0000) begin n_err++;
      $display("FAIL fwd_ex_wins: got %h want aaaa0000", pipe_id.regs_rddata0); end
    ex_wreq.we = 1'b0;
    step();
    n_vec++; if (pipe_id.regs_rddata0 !== 32'h00001111) begin n_err++;
      $display("FAIL fwd_wb: got %h want 00001111", pipe_id.regs_rddata0); end
    wb_wreq.we = 1'b0;
    step();
    n_vec++; if (pipe_id.regs_rddata0 !== 32'h0) begin n_err++;
      $display("FAIL fwd_rf_r5: got %h want 0", pipe_id.regs_rddata0); end
    set_if(32'h00221821, 32'hBFC00004);   // addu r3,r1,r2
    step();
    n_vec++; if (pipe_id.regs_rddata0 !== 32'h1000 || pipe_id.regs_rddata1 !== 32'hA5)
      begin n_err++; $display("FAIL fwd_rf: got %h/%h want 00001000/000000a5",
                              pipe_id.regs_rddata0, pipe_id.regs_rddata1); end
  endtask

  task automatic test_r0();
    ex_wreq.we = 1'b1; ex_wreq.waddr = 5'd0; ex_wreq.wrdata = 32'hFFFFFFFF;
    wb_wreq.we = 1'b1; wb_wreq.waddr = 5'd0; wb_wreq.wrdata = 32'hFFFFFFFF;
    set_if(32'h00001821, 32'hBFC00008);   // addu r3,r0,r0
    step();
    n_vec++; if (pipe_id.regs_rddata0 !== 32'h0 || pipe_id.regs_rddata1 !== 32'h0) begin
      n_err++; $display("FAIL r0_protect: got %h/%h want 0/0", pipe_id.regs_rddata0,
                        pipe_id.regs_rddata1); end
    ex_wreq = '0; wb_wreq = '0;
  endtask

  task automatic test_imm();
    set_if(32'h2426FFFC, 32'hBFC0000C);   // addiu r6,r1,-4
    #1;
    n_vec++; if (regs_raddr1 !== 5'd6) begin n_err++;
      $display("FAIL imm_raddr1: got %0d want 6", regs_raddr1); end
    step();
    n_vec++; if (pipe_id.regs_rddata1 !== 32'hFFFFFFFC || pipe_id.regs_rddata0 !== 32'h1000)
      begin n_err++; $display("FAIL imm_sext: got %h/%h want 00001000/fffffffc",
                              pipe_id.regs_rddata0, pipe_id.regs_rddata1); end
    set_if(32'h3426FFFC, 32'hBFC00010);   // ori r6,r1,0xfffc
    step();
    n_vec++; if (pipe_id.regs_rddata1 !== 32'h0000FFFC) begin n_err++;
      $display("FAIL imm_zext: got %h want 0000fffc", pipe_id.regs_rddata1); end
    set_if(32'h3C061234, 32'hBFC00014);   // lui r6,0x1234
    step();
    n_vec++; if (pipe_id.regs_rddata1 !== 32'h12340000) begin n_err++;
      $display("FAIL imm_lui: got %h want 12340000", pipe_id.regs_rddata1); end
  endtask

  task automatic test_mem();
    set_if(32'h8C240008, 32'hBFC00018);   // lw r4,8(r1)
    step();
    n_vec++; if (pipe_id.dcache_req.read !== 1'b1 || pipe_id.dcache_req.write !== 1'b0 ||
                 pipe_id.dcache_req.vaddr !== 32'h1008 ||
                 pipe_id.dcache_req.byteenable !== 4'hF) begin n_err++;
      $display("FAIL mem_lw: got %h want r=1 w=0 va=00001008 be=f", pipe_id.dcache_req); end
    set_if(32'hA0220002, 32'hBFC0001C);   // sb r2,2(r1)
    step();
    n_vec++; if (pipe_id.dcache_req.write !== 1'b1 || pipe_id.dcache_req.read !== 1'b0 ||
                 pipe_id.dcache_req.vaddr !== 32'h1002 ||
                 pipe_id.dcache_req.wrdata !== 32'h00A50000 ||
                 pipe_id.dcache_req.byteenable !== 4'b0100) begin n_err++;
      $display("FAIL mem_sb: got %h want w=1 va=00001002 wd=00a50000 be=4",
               pipe_id.dcache_req); end
    set_if(32'h8C240008, 32'hBFC00020);
    pipe_if.valid = 1'b0;
    step();
    n_vec++; if (pipe_id.valid !== 1'b0 || pipe_id.dcache_req.read !== 1'b0) begin n_err++;
      $display("FAIL mem_gate: got v=%b r=%b want 0/0", pipe_id.valid,
               pipe_id.dcache_req.read); end
  endtask

  task automatic test_delay_slot();
    set_if(32'h10220004, 32'hBFC00000);   // beq r1,r2,4
    step();
    n_vec++; if (pipe_id.op !== OP_BEQ || pipe_id.delayslot !== 1'b0) begin n_err++;
      $display("FAIL ds_branch: got op=%0d ds=%b want op=%0d ds=0", pipe_id.op,
               pipe_id.delayslot, OP_BEQ); end
    set_if(32'h00A01821, 32'hBFC00004);
    step();
    n_vec++; if (pipe_id.delayslot !== 1'b1 || pipe_id.vaddr !== 32'hBFC00004) begin
      n_err++; $display("FAIL ds_slot: got ds=%b va=%h want 1/bfc00004", pipe_id.delayslot,
                        pipe_id.vaddr); end
    set_if(32'h00A01821, 32'hBFC00008);
    step();
    n_vec++; if (pipe_id.delayslot !== 1'b0) begin n_err++;
      $display("FAIL ds_after: got %b want 0", pipe_id.delayslot); end
  endtask

  task automatic test_cp0();
    set_if(32'h40826000, 32'hBFC00030);   // mtc0 r2,$12
    step();
    n_vec++; if (pipe_id.op !== OP_MTC0 || pipe_id.regs_rddata1 !== 32'hA5) begin n_err++;
      $display("FAIL cp0_mtc0: got op=%0d d=%h want op=%0d d=000000a5", pipe_id.op,
               pipe_id.regs_rddata1, OP_MTC0); end
    set_if(32'h40036000, 32'hBFC00034);   // mfc0 r3,$12
    #1;
    n_vec++; if (ready_o !== 1'b0) begin n_err++;
      $display("FAIL cp0_ready: got %b want 0", ready_o); end
    step();
    n_vec++; if (pipe_id.valid !== 1'b0 || ready_o !== 1'b1) begin n_err++;
      $display("FAIL cp0_bubble: got v=%b rdy=%b want 0/1", pipe_id.valid, ready_o); end
    step();
    n_vec++; if (pipe_id.valid !== 1'b1 || pipe_id.op !== OP_MFC0 ||
                 pipe_id.cp0_rreq.raddr !== 5'd12 || pipe_id.cp0_rreq.rsel !== 3'd0) begin
      n_err++; $display("FAIL cp0_mfc0: got v=%b op=%0d rq=%h want 1/%0d/60", pipe_id.valid,
                        pipe_id.op, pipe_id.cp0_rreq, OP_MFC0); end
  endtask

  task automatic test_backpressure();
    set_if(32'h10220004, 32'hBFC00010);   // beq sets ds_pending
    step();
    ready_i = 1'b0;
    ex_wreq.we = 1'b1; ex_wreq.waddr = 5'd1; ex_wreq.wrdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      set_if(32'h00A01821, 32'hBFC00014 + 32'(i));
      #1;
      n_vec++; if (ready_o !== 1'b0) begin n_err++;
        $display("FAIL bp_ready[%0d]: got %b want 0", i, ready_o); end
      step();
      n_vec++; if (pipe_id.vaddr !== 32'hBFC00010 || pipe_id.op !== OP_BEQ ||
                   pipe_id.regs_rddata0 !== 32'h1000) begin n_err++;
        $display("FAIL bp_hold[%0d]: got va=%h d0=%h want bfc00010/00001000", i,
                 pipe_id.vaddr, pipe_id.regs_rddata0); end
    end
    ex_wreq = '0;
    ready_i = 1'b1;
    set_if(32'h00A01821, 32'hBFC00014);
    step();
    n_vec++; if (pipe_id.delayslot !== 1'b1 || pipe_id.vaddr !== 32'hBFC00014) begin
      n_err++; $display("FAIL bp_release: got ds=%b va=%h want 1/bfc00014",
                        pipe_id.delayslot, pipe_id.vaddr); end
  endtask

  task automatic test_flush();
    set_if(32'h10220004, 32'h00000100);
    step();
    set_if(32'h8C240008, 32'h00000104);
    except_req.valid = 1'b1;
    step();
    n_vec++; if (pipe_id !== '0) begin n_err++;
      $display("FAIL flush_pipe_id: got %h want 0", pipe_id); end
    except_req.valid = 1'b0;
    set_if(32'h00A01821, 32'h00000180);
    step();
    n_vec++; if (pipe_id.valid !== 1'b1 || pipe_id.delayslot !== 1'b0) begin n_err++;
      $display("FAIL flush_ds: got v=%b ds=%b want 1/0", pipe_id.valid, pipe_id.delayslot); end
    set_if(32'h10220004, 32'h00000200);
    step();
    ready_i = 1'b0; rst = 1'b1;
    set_if(32'h00A01821, 32'h00000204);
    step();
    n_vec++; if (pipe_id !== '0) begin n_err++;
      $display("FAIL rst_stall_pipe_id: got %h want 0", pipe_id); end
    rst = 1'b0; ready_i = 1'b1;
    step();
    n_vec++; if (pipe_id.valid !== 1'b1 || pipe_id.delayslot !== 1'b0) begin n_err++;
      $display("FAIL rst_stall_ds: got v=%b ds=%b want 1/0", pipe_id.valid,
               pipe_id.delayslot); end
  endtask

  task automatic test_invalid();
    set_if(32'hFC000000, 32'hBFC00001);
    pipe_if.iaddr_ex = 1'b1;
    step();
    n_vec++; if (pipe_id.valid !== 1'b1 || pipe_id.op !== OP_INVALID ||
                 pipe_id.iaddr_ex !== 1'b1) begin n_err++;
      $display("FAIL invalid_op: got v=%b op=%0d ex=%b want 1/%0d/1", pipe_id.valid,
               pipe_id.op, pipe_id.iaddr_ex, OP_INVALID); end
    pipe_if.valid = 1'b0; pipe_if.iaddr_ex = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    rf[1] = 32'h00001000;
    rf[2] = 32'h000000A5;
    rf[5] = 32'h00000000;
    pipe_if = '0;
    test_reset();
    test_forward();
    test_r0();
    test_imm();
    test_mem();
    test_delay_slot();
    test_cp0();
    test_backpressure();
    test_flush();
    test_invalid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
